// File: rtl/pe_dot_sched.sv
// Dot-product sequencer: clears one MAC PE, streams paired operands from two
// synchronous-read buffers into it, then holds the accumulated sum on a valid/ready port.
module pe_dot_sched #(
   parameter int BW     = 8,
   parameter int LEN_W  = 8,
   parameter int ADDR_W = 8
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [ADDR_W-1:0] i_act_base,
   input  logic [ADDR_W-1:0] i_wt_base,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_act_addr,
   output logic [ADDR_W-1:0] o_wt_addr,
   input  logic [BW-1:0]     i_act_data,
   input  logic [BW-1:0]     i_wt_data,
   output logic              o_pe_clear,
   output logic [BW-1:0]     o_pe_activation,
   output logic [BW-1:0]     o_pe_weight,
   input  logic [2*BW-1:0]   i_pe_output,
   output logic              o_busy,
   output logic              o_valid,
   output logic [2*BW-1:0]   o_result,
   input  logic              i_result_ready
);

   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, CAPTURE, DONE} state_t;

   state_t              state;
   logic [LEN_W-1:0]    len_r;
   logic [LEN_W-1:0]    idx;
   logic [ADDR_W-1:0]   act_base_r;
   logic [ADDR_W-1:0]   wt_base_r;
   logic                rd_vld;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         len_r      <= '0;
         idx        <= '0;
         act_base_r <= '0;
         wt_base_r  <= '0;
         rd_vld     <= 1'b0;
         o_rd_en    <= 1'b0;
         o_act_addr <= '0;
         o_wt_addr  <= '0;
         o_pe_clear <= 1'b0;
         o_busy     <= 1'b0;
         o_valid    <= 1'b0;
         o_result   <= '0;
      end else begin
         // read data returns one cycle after the strobe
         rd_vld <= o_rd_en;
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_busy <= 1'b1;
                  if (i_len != '0) begin
                     len_r      <= i_len;
                     act_base_r <= i_act_base;
                     wt_base_r  <= i_wt_base;
                     o_pe_clear <= 1'b1;
                     state      <= CLEAR;
                  end else begin
                     o_result <= '0;
                     o_valid  <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            CLEAR: begin
               o_pe_clear <= 1'b0;
               o_rd_en    <= 1'b1;
               o_act_addr <= act_base_r;
               o_wt_addr  <= wt_base_r;
               idx        <= '0;
               state      <= FETCH;
            end
            FETCH: begin
               if (idx == len_r - LEN_W'(1)) begin
                  o_rd_en <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  idx        <= idx + LEN_W'(1);
                  o_act_addr <= o_act_addr + ADDR_W'(1);
                  o_wt_addr  <= o_wt_addr + ADDR_W'(1);
               end
            end
            DRAIN: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               o_result <= i_pe_output;
               o_valid  <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               if (o_valid && i_result_ready) begin
                  o_valid <= 1'b0;
                  o_busy  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The PE accumulates every edge, so it must see zeros whenever no read data is live.
   assign o_pe_activation = rd_vld ? i_act_data : '0;
   assign o_pe_weight     = rd_vld ? i_wt_data  : '0;

endmodule

// File: tb/tb_pe_dot_sched.sv
// Bench for pe_dot_sched: buffer and PE models around the DUT, results scoreboarded.
module tb_pe_dot_sched;

   localparam int BW     = 8;
   localparam int LEN_W  = 8;
   localparam int ADDR_W = 8;

   logic              i_clock = 1'b0;
   logic              i_reset;
   logic              i_start;
   logic [LEN_W-1:0]  i_len;
   logic [ADDR_W-1:0] i_act_base;
   logic [ADDR_W-1:0] i_wt_base;
   logic              o_rd_en;
   logic [ADDR_W-1:0] o_act_addr;
   logic [ADDR_W-1:0] o_wt_addr;
   logic [BW-1:0]     i_act_data;
   logic [BW-1:0]     i_wt_data;
   logic              o_pe_clear;
   logic [BW-1:0]     o_pe_activation;
   logic [BW-1:0]     o_pe_weight;
   logic [2*BW-1:0]   i_pe_output;
   logic              o_busy;
   logic              o_valid;
   logic [2*BW-1:0]   o_result;
   logic              i_result_ready;

   int errors = 0;
   int checks = 0;

   logic [BW-1:0] act_mem [256];
   logic [BW-1:0] wt_mem  [256];
   int exp_q[$];
   int act_q[$];
   int wt_q[$];
   logic rd_en_d;

   pe_dot_sched #(.BW(BW), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_len(i_len),
      .i_act_base(i_act_base), .i_wt_base(i_wt_base), .o_rd_en(o_rd_en),
      .o_act_addr(o_act_addr), .o_wt_addr(o_wt_addr), .i_act_data(i_act_data),
      .i_wt_data(i_wt_data), .o_pe_clear(o_pe_clear), .o_pe_activation(o_pe_activation),
      .o_pe_weight(o_pe_weight), .i_pe_output(i_pe_output), .o_busy(o_busy),
      .o_valid(o_valid), .o_result(o_result), .i_result_ready(i_result_ready)
   );

   always #5 i_clock = ~i_clock;

   // synchronous-read operand buffers
   always @(posedge i_clock) begin
      if (o_rd_en) begin
         i_act_data <= act_mem[o_act_addr];
         i_wt_data  <= wt_mem[o_wt_addr];
      end
   end

   // PE: synchronous clear, otherwise accumulate modulo 2^(2*BW)
   initial i_pe_output = '0;
   always @(posedge i_clock) begin
      if (o_pe_clear) i_pe_output <= '0;
      else            i_pe_output <= i_pe_output + o_pe_activation * o_pe_weight;
   end

   always @(posedge i_clock or posedge i_reset) begin
      if (i_reset) rd_en_d <= 1'b0;
      else         rd_en_d <= o_rd_en;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard: addresses, operand gating, results
   always @(negedge i_clock) begin
      if (!i_reset) begin
         check("pe_act_gate", int'(o_pe_activation), rd_en_d ? int'(i_act_data) : 0);
         check("pe_wt_gate",  int'(o_pe_weight),     rd_en_d ? int'(i_wt_data)  : 0);
         if (o_rd_en) begin
            if (act_q.size() == 0) check("spurious_rd", 1, 0);
            else begin
               check("act_addr", int'(o_act_addr), act_q.pop_front());
               check("wt_addr",  int'(o_wt_addr),  wt_q.pop_front());
            end
         end
         if (o_valid && i_result_ready) begin
            if (exp_q.size() == 0) check("spurious_valid", 1, 0);
            else check("result", int'(o_result), exp_q.pop_front());
         end
      end
   end

   task automatic run_job(input int len, input int ab, input int wb, input bit rdy);
      int sum;
      int n;
      sum = 0;
      for (int i = 0; i < len; i++) begin
         sum += int'(act_mem[(ab + i) & 255]) * int'(wt_mem[(wb + i) & 255]);
         act_q.push_back((ab + i) & 255);
         wt_q.push_back((wb + i) & 255);
      end
      exp_q.push_back(sum & 16'hFFFF);
      i_result_ready = rdy;
      @(negedge i_clock);
      i_start    = 1'b1;
      i_len      = LEN_W'(len);
      i_act_base = ADDR_W'(ab);
      i_wt_base  = ADDR_W'(wb);
      @(negedge i_clock);
      i_start    = 1'b0;
      i_len      = LEN_W'($urandom);
      i_act_base = ADDR_W'($urandom);
      i_wt_base  = ADDR_W'($urandom);
      n = 1;
      while (!o_valid && n < 60) begin
         @(negedge i_clock);
         n++;
      end
      check("latency", n, (len == 0) ? 1 : len + 4);
   endtask

   task automatic fill(input int ab, input int wb, input int len, input int av, input int wv);
      for (int i = 0; i < len; i++) begin
         act_mem[(ab + i) & 255] = BW'(av);
         wt_mem[(wb + i) & 255]  = BW'(wv);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         act_mem[i] = BW'(i);
         wt_mem[i]  = BW'(255 - i);
      end
      i_reset = 1'b1; i_start = 1'b0; i_len = '0; i_act_base = '0; i_wt_base = '0;
      i_result_ready = 1'b0; i_act_data = '0; i_wt_data = '0;
      #12;
      check("rst_rd_en", int'(o_rd_en), 0);
      check("rst_addr", int'(o_act_addr) + int'(o_wt_addr), 0);
      check("rst_clear", int'(o_pe_clear), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_valid", int'(o_valid), 0);
      check("rst_result", int'(o_result), 0);
      @(negedge i_clock);
      i_reset = 1'b0;

      // basic: len 4, all ones, ready held
      fill(8, 40, 4, 1, 1);
      run_job(4, 8, 40, 1'b1);
      @(negedge i_clock);
      check("valid_pulse", int'(o_valid), 0);

      // mixed operands with backpressure
      act_mem[16] = 8'd128; act_mem[17] = 8'd128; act_mem[18] = 8'd128;
      wt_mem[60] = 8'd1; wt_mem[61] = 8'd2; wt_mem[62] = 8'd3;
      run_job(3, 16, 60, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check("hold_valid", int'(o_valid), 1);
         check("hold_result", int'(o_result), 768);
         check("hold_busy", int'(o_busy), 1);
         i_start = (k == 2);
         i_len   = 8'd3;
         @(negedge i_clock);
      end
      i_start = 1'b0;
      @(posedge i_clock);
      #1 i_result_ready = 1'b1;
      @(negedge i_clock);
      @(negedge i_clock);
      check("ack_busy", int'(o_busy), 0);
      check("ack_valid", int'(o_valid), 0);
      repeat (4) @(negedge i_clock);
      check("no_second_job", int'(o_busy), 0);

      // zero length
      run_job(0, 0, 0, 1'b1);
      @(negedge i_clock);
      check("zero_valid_pulse", int'(o_valid), 0);

      // address wrap
      run_job(4, 254, 10, 1'b1);

      // overflow of the accumulator
      fill(100, 200, 2, 255, 255);
      run_job(2, 100, 200, 1'b1);

      // reset in the second FETCH cycle
      fill(0, 0, 4, 1, 1);
      for (int i = 0; i < 4; i++) begin
         act_q.push_back(i);
         wt_q.push_back(i);
      end
      @(negedge i_clock);
      i_start = 1'b1; i_len = 8'd4; i_act_base = '0; i_wt_base = '0;
      @(negedge i_clock);
      i_start = 1'b0;
      n = 0;
      while (!o_rd_en && n < 20) begin
         @(negedge i_clock);
         n++;
      end
      check("fetch_reached", int'(o_rd_en), 1);
      @(negedge i_clock);
      #2 i_reset = 1'b1;
      #1;
      check("mid_rst_rd_en", int'(o_rd_en), 0);
      check("mid_rst_busy", int'(o_busy), 0);
      check("mid_rst_valid", int'(o_valid), 0);
      check("mid_rst_pe_in", int'(o_pe_activation) + int'(o_pe_weight) + int'(o_pe_clear), 0);
      check("mid_rst_addr", int'(o_act_addr) + int'(o_wt_addr), 0);
      act_q.delete();
      wt_q.delete();
      @(negedge i_clock);
      i_reset = 1'b0;
      run_job(4, 0, 0, 1'b1);
      @(negedge i_clock);
      check("queue_empty", exp_q.size() + act_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
